// File: rtl/trace_pkg.sv
// Shared types for the retirement trace buffer.
//   trace_entry_t : one retired instruction as stored in the trace FIFO
//   fifo_op_e     : per-cycle FIFO operation, used to update occupancy
package trace_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] seq;
  } trace_entry_t;

  // Encoded as {push, pop} so it can be built straight from the two accepts.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace_entry_t, DEPTH entries (power of two, >= 2).
// Has no knowledge of sequence numbers or drop accounting.
//
// Ports
//   clock       in   sole clock
//   reset       in   synchronous, active-high
//   push        in   request to write push_data
//   push_data   in   entry to write
//   push_accept out  push request taken this cycle (not full, or full with pop)
//   pop         in   request to remove the head entry
//   head        out  head entry; all-zero while empty
//   empty       out  no entries stored
//   count       out  occupancy, 0..DEPTH
module trace_fifo
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  trace_entry_t             push_data,
  output logic                     push_accept,
  input  logic                     pop,
  output trace_entry_t             head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  trace_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           full;
  logic           pop_accept;
  fifo_op_e       op;

  // Full/empty come from the occupancy counter; with naturally wrapping
  // pointers a pointer compare could not tell the two apart.
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign pop_accept  = pop & ~empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_accept = push & (~full | pop_accept);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    op = FIFO_IDLE;
    case ({push_accept, pop_accept})
      2'b01:   op = FIFO_POP;
      2'b10:   op = FIFO_PUSH;
      2'b11:   op = FIFO_BOTH;
      default: op = FIFO_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop_accept)  rd_ptr <= rd_ptr + AW'(1);
      unique case (op)
        FIFO_PUSH: count <= count + CW'(1);
        FIFO_POP:  count <= count - CW'(1);
        default:   count <= count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; only valid entries are
  // ever observed, and the head output is forced to zero while empty.
  always_ff @(posedge clock) begin
    if (push_accept) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/inst_trace_buf.sv
// Retirement trace buffer. Captures instructions retired at writeback into a
// FIFO and drains them one per handshake to the disassembly stage. On overflow
// the retirement is dropped (never stalls the core) and counted.
//
// Ports
//   clock        in   sole clock
//   reset        in   synchronous, active-high
//   trace_en     in   capture enable; when low nothing is stored or numbered
//   wb_valid     in   one instruction retires this cycle
//   wb_pc        in   PC of retiring instruction
//   wb_inst      in   instruction word of retiring instruction
//   trace_valid  out  head entry available
//   trace_ready  in   consumer accepts head this cycle
//   trace_pc     out  head PC
//   trace_inst   out  head instruction word
//   trace_seq    out  head sequence number
//   count        out  current occupancy
//   overflow     out  sticky; set on first drop
//   drop_cnt     out  dropped retirements, saturating
module inst_trace_buf
  import trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    trace_en,
  input  logic                    wb_valid,
  input  logic [31:0]             wb_pc,
  input  logic [31:0]             wb_inst,
  output logic                    trace_valid,
  input  logic                    trace_ready,
  output logic [31:0]             trace_pc,
  output logic [31:0]             trace_inst,
  output logic [31:0]             trace_seq,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic [DROP_W-1:0]       drop_cnt
);

  logic          capture;
  logic          push_accept;
  logic          drop;
  logic          empty;
  logic [31:0]   seq_ctr;
  trace_entry_t  new_entry;
  trace_entry_t  head;

  assign capture = wb_valid & trace_en;

  // The entry carries the pre-increment sequence number.
  assign new_entry = '{pc: wb_pc, inst: wb_inst, seq: seq_ctr};

  trace_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push        (capture),
    .push_data   (new_entry),
    .push_accept (push_accept),
    .pop         (trace_ready),
    .head        (head),
    .empty       (empty),
    .count       (count)
  );

  assign drop = capture & ~push_accept;

  // The sequence counter advances on dropped captures too, so a gap in
  // trace_seq downstream shows exactly how many retirements were lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_ctr  <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture) seq_ctr <= seq_ctr + 32'd1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      end
    end
  end

  assign trace_valid = ~empty;
  assign trace_pc    = head.pc;
  assign trace_inst  = head.inst;
  assign trace_seq   = head.seq;

endmodule
